i2c_target_rx: RTL and testbench

Write-only I2C target (slave) receiver: the far end of the bus our controller-side senders drive. It watches `sda`/`scl`, detects START/STOP, matches its 7-bit address, ACKs accepted bytes and delivers each data byte on a valid/ready port. It serves as an on-FPGA LCD stand-in and loopback checker for the controller path, and as the receive front end for any FPGA-hosted I2C peripheral.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 58 +++++
 rtl/i2c_target_rx.sv | 164 ++++++++++++++++
 tb/tb_i2c_target_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the controller-side senders and the target
// receiver: LCD target address and byte constants, controller bit-phase
// positions (in clock cycles within one bit) and the target state enum.
package i2c_pkg;

    localparam logic [6:0] LCD_ADDR       = 7'h72;
    localparam logic [7:0] LCD_ADDR_BYTE  = {LCD_ADDR, 1'b0};   // 8'hE4, write
    localparam logic [7:0] LCD_CMD_BYTE   = 8'h7C;              // settings command prefix
    localparam logic [7:0] LCD_CLEAR_BYTE = 8'h2D;              // clear display

    // Controller bit phasing: SCL low 0..RISE, high RISE..FALL, low FALL..END.
    localparam int unsigned BIT_RISE      = 125;
    localparam int unsigned BIT_FALL      = 375;
    localparam int unsigned BIT_CYCLE_END = 500;

    typedef enum logic [2:0] {
        TGT_IDLE,
        TGT_ADDR,
        TGT_ADDR_ACK,
        TGT_DATA,
        TGT_DATA_ACK,
        TGT_IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Line conditioner for one I2C wire: 2-FF synchroniser followed by a glitch
// filter that only follows the synchronised level once it has been stable
// for FILTER_LEN cycles. Filtered level and its edge strobes are registered.
//   clock, reset_n : system clock, async active-low reset
//   line_i         : raw pad level
//   level_o        : filtered level (resets to 1)
//   rise_o/fall_o  : one-cycle strobes, coincident with level_o changing
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            // Down-counter restarts whenever the synchronised level agrees
            // with the filtered one; terminal count commits the new level.
            if (sync2_q == level_q) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver. Detects START/STOP, matches a 7-bit write
// address, ACKs accepted bytes and presents each data byte on valid/ready.
//   clock, reset_n  : system clock, async active-low reset
//   sda (inout)     : bus data, only ever pulled low for ACK
//   scl             : bus clock, never stretched
//   rx_data/rx_valid/rx_ready : received byte handshake
//   frame_start/frame_end     : START (incl. repeated) / STOP pulses
//   addressed       : address ACKed, until STOP or next START
//   overrun         : sticky, data byte NAKed because rx_data was still full
//
// state        | meaning
// TGT_IDLE     | waiting for START
// TGT_ADDR     | shifting address byte
// TGT_ADDR_ACK | address matched, ACK clock in progress
// TGT_DATA     | shifting data byte
// TGT_DATA_ACK | data byte loaded, ACK clock in progress
// TGT_IGNORE   | not for us / NAKed, wait for STOP or START
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR       = LCD_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    inout  tri1        sda,
    input  logic       scl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       addressed,
    output logic       overrun
);

    logic sda_lvl, sda_rise, sda_fall;
    logic scl_lvl, scl_rise, scl_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clock(clock), .reset_n(reset_n), .line_i(sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clock(clock), .reset_n(reset_n), .line_i(scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       ack_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, frame_start_q, frame_end_q, addressed_q, overrun_q;

    logic       start_det, stop_det, bus_evt, last_bit, in_ack;
    logic [7:0] byte_in;
    logic       shift_en, load_byte, nak_data, ack_on, ack_off;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign bus_evt   = start_det | stop_det;
    assign byte_in   = {shift_q[6:0], sda_lvl};
    assign last_bit  = scl_rise && (bit_cnt_q == 3'd0);
    assign in_ack    = (state_q == TGT_ADDR_ACK) || (state_q == TGT_DATA_ACK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= TGT_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = TGT_ADDR;
        end else if (stop_det) begin
            state_d = TGT_IDLE;
        end else begin
            case (state_q)
                TGT_IDLE:   state_d = TGT_IDLE;
                TGT_ADDR:   if (last_bit)
                                state_d = (byte_in == {ADDR, 1'b0}) ? TGT_ADDR_ACK : TGT_IGNORE;
                TGT_ADDR_ACK,
                TGT_DATA_ACK: if (scl_fall && ack_q) state_d = TGT_DATA;
                TGT_DATA:   if (last_bit)
                                state_d = rx_valid_q ? TGT_IGNORE : TGT_DATA_ACK;
                TGT_IGNORE: state_d = TGT_IGNORE;
                default:    state_d = TGT_IDLE;
            endcase
        end
    end

    // ACK spans from the SCL fall ending bit 8 to the SCL fall ending the
    // ACK clock; ack_q itself tells the two falls apart.
    always_comb begin
        shift_en  = 1'b0;
        load_byte = 1'b0;
        nak_data  = 1'b0;
        ack_on    = 1'b0;
        ack_off   = 1'b0;
        if (!bus_evt) begin
            shift_en  = scl_rise && ((state_q == TGT_ADDR) || (state_q == TGT_DATA));
            load_byte = (state_q == TGT_DATA) && last_bit && !rx_valid_q;
            nak_data  = (state_q == TGT_DATA) && last_bit &&  rx_valid_q;
            ack_on    = in_ack && scl_fall && !ack_q;
            ack_off   = in_ack && scl_fall &&  ack_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q     <= 3'd7;
            shift_q       <= 8'h00;
            ack_q         <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            addressed_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_start_q <= start_det;
            frame_end_q   <= stop_det;

            if (start_det || ack_off) bit_cnt_q <= 3'd7;
            else if (shift_en)        bit_cnt_q <= bit_cnt_q - 3'd1;

            if (start_det)     shift_q <= 8'h00;
            else if (shift_en) shift_q <= byte_in;

            if (bus_evt) begin
                ack_q       <= 1'b0;
                addressed_q <= 1'b0;
            end else begin
                if (ack_on)  ack_q <= 1'b1;
                if (ack_off) ack_q <= 1'b0;
                if (ack_on && (state_q == TGT_ADDR_ACK)) addressed_q <= 1'b1;
            end

            // A load in the same cycle as a consume keeps rx_valid set.
            if (load_byte) begin
                rx_data_q  <= byte_in;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (start_det)     overrun_q <= 1'b0;
            else if (nak_data) overrun_q <= 1'b1;
        end
    end

    // Gated by reset_n so an ACK in flight is dropped the instant reset asserts.
    assign sda = (ack_q && reset_n) ? 1'b0 : 1'bz;

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign addressed   = addressed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: drives the bus like a write-only controller and
// checks ACK slots and the receive port against a transaction-level model.
module tb_i2c_target_rx;
    import i2c_pkg::*;

    localparam int Q = int'(BIT_RISE / 10);
    localparam int H = int'((BIT_FALL - BIT_RISE) / 10);
    localparam int T = int'((BIT_CYCLE_END - BIT_FALL) / 10);

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       tb_sda = 1'b1;
    logic       rx_ready = 1'b0;
    tri1        sda;
    logic [7:0] rx_data;
    logic       rx_valid, frame_start, frame_end, addressed, overrun;

    assign sda = tb_sda ? 1'bz : 1'b0;

    i2c_target_rx #(.ADDR(LCD_ADDR), .FILTER_LEN(3)) dut (
        .clock(clock), .reset_n(reset_n), .sda(sda), .scl(scl),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_start(frame_start), .frame_end(frame_end),
        .addressed(addressed), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0, fe_cnt = 0, dut_low_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Transaction-level model of the target
    bit         m_valid = 0, m_overrun = 0, m_addressed = 0, m_ignore = 0;
    logic [7:0] m_data = 8'h00;

    always @(negedge clock) begin
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (tb_sda && sda === 1'b0) dut_low_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        m_overrun = 0; m_addressed = 0; m_ignore = 0;
    endtask

    task automatic model_addr(input logic [7:0] b, output bit ack);
        m_addressed = (b == {LCD_ADDR, 1'b0});
        m_ignore = !m_addressed;
        ack = m_addressed;
    endtask

    task automatic model_data(input logic [7:0] b, output bit ack);
        ack = 0;
        if (!m_ignore) begin
            if (m_valid) begin
                m_overrun = 1; m_ignore = 1;
            end else begin
                ack = 1; m_data = b; exp_q.push_back(b);
                m_valid = !rx_ready;
            end
        end
    endtask

    task automatic bus_start();
        tb_sda = 1'b1; scl = 1'b1; tick(Q);
        tb_sda = 1'b0; tick(H);
        scl = 1'b0; tick(T);
    endtask

    task automatic bus_rep_start();
        tb_sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        tb_sda = 1'b0; tick(Q);
        scl = 1'b0; tick(T);
    endtask

    task automatic bus_stop();
        tb_sda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        tb_sda = 1'b1; tick(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            tb_sda = b[7-i]; tick(Q);
            scl = 1'b1;
            if (glitch && i == 3) begin
                tick(H/2); scl = 1'b0; tick(2); scl = 1'b1; tick(H - H/2 - 2);
            end else begin
                tick(H);
            end
            scl = 1'b0; tick(T);
        end
    endtask

    // Returns {SDA low just after the 9th SCL rise, SDA low just before its fall}
    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic [1:0] ack);
        logic a0, a1;
        send_bits(b, 8, glitch);
        tb_sda = 1'b1; tick(Q);
        scl = 1'b1; tick(2);
        a0 = (sda === 1'b0);
        tick(H - 2);
        a1 = (sda === 1'b0);
        scl = 1'b0; tick(T);
        ack = {a0, a1};
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1; tick(3);
        m_valid = 0;
        check($sformatf("%s rx_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s rx_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete(); exp_q.delete();
    endtask

    task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] d [4],
                            input int n, input bit glitch);
        int fs0, fe0, low0;
        logic [1:0] ack;
        bit e, any_ack;
        fs0 = fs_cnt; fe0 = fe_cnt; low0 = dut_low_cnt;
        bus_start(); model_start();
        check($sformatf("%s frame_start", tag), 32'(fs_cnt - fs0), 32'd1);
        send_byte(a, 1'b0, ack);
        model_addr(a, e); any_ack = e;
        check($sformatf("%s addr_ack", tag), 32'(ack), 32'({e, e}));
        check($sformatf("%s addressed", tag), 32'(addressed), 32'(m_addressed));
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], glitch && i == 0, ack);
            model_data(d[i], e); any_ack |= e;
            check($sformatf("%s data%0d_ack", tag, i), 32'(ack), 32'({e, e}));
        end
        check($sformatf("%s rx_data", tag), 32'(rx_data), 32'(m_data));
        check($sformatf("%s rx_valid", tag), 32'(rx_valid), 32'(m_valid));
        check($sformatf("%s overrun", tag), 32'(overrun), 32'(m_overrun));
        bus_stop();
        check($sformatf("%s frame_end", tag), 32'(fe_cnt - fe0), 32'd1);
        check($sformatf("%s addressed_after_stop", tag), 32'(addressed), 32'd0);
        check($sformatf("%s overrun_after_stop", tag), 32'(overrun), 32'(m_overrun));
        if (!any_ack)
            check($sformatf("%s sda_never_driven", tag), 32'(dut_low_cnt - low0), 32'd0);
    endtask

    initial begin
        logic [1:0] ack;
        logic [7:0] a, x;
        int n, fs0;
        bit e;

        tick(3);
        check("reset sda", 32'(sda), 32'd1);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset flags", 32'({frame_start, frame_end, addressed, overrun}), 32'd0);
        reset_n = 1'b1; tick(10);

        rx_ready = 1'b1;
        do_frame("lcd", LCD_ADDR_BYTE, '{LCD_CMD_BYTE, LCD_CLEAR_BYTE, 8'h00, 8'h00}, 2, 1'b0);
        drain("lcd");

        do_frame("mismatch", 8'hE6, '{8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        drain("mismatch");
        do_frame("read", 8'hE5, '{8'h31, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        drain("read");

        rx_ready = 1'b0;
        do_frame("overrun", LCD_ADDR_BYTE, '{8'h48, 8'h45, 8'h4C, 8'h00}, 3, 1'b0);
        tick(1);
        rx_ready = 1'b1; tick(1);
        check("overrun consume_next_cycle", 32'(rx_valid), 32'd0);
        drain("overrun");

        // Repeated START after 4 data bits
        bus_start(); model_start();
        send_byte(LCD_ADDR_BYTE, 1'b0, ack);
        model_addr(LCD_ADDR_BYTE, e);
        check("rstart addr_ack", 32'(ack), 32'({e, e}));
        send_bits(8'hA5, 4, 1'b0);
        fs0 = fs_cnt;
        bus_rep_start(); model_start();
        check("rstart frame_start", 32'(fs_cnt - fs0), 32'd1);
        check("rstart addressed_cleared", 32'(addressed), 32'd0);
        send_byte(LCD_ADDR_BYTE, 1'b0, ack);
        model_addr(LCD_ADDR_BYTE, e);
        check("rstart addr2_ack", 32'(ack), 32'({e, e}));
        send_byte(8'h4F, 1'b0, ack);
        model_data(8'h4F, e);
        check("rstart data_ack", 32'(ack), 32'({e, e}));
        bus_stop();
        drain("rstart");

        do_frame("glitch", LCD_ADDR_BYTE, '{8'($urandom), 8'h00, 8'h00, 8'h00}, 1, 1'b1);
        drain("glitch");

        for (int f = 0; f < 8; f++) begin
            a = ($urandom_range(0, 9) < 7) ? LCD_ADDR_BYTE : 8'($urandom);
            n = int'($urandom_range(1, 3));
            rx_ready = 1'($urandom_range(0, 1));
            do_frame($sformatf("rand%0d", f), a,
                     '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, n, 1'b0);
            drain($sformatf("rand%0d", f));
        end

        // Reset while the address ACK is being driven, with a byte still held
        rx_ready = 1'b0;
        x = 8'($urandom_range(1, 255));
        do_frame("prereset", LCD_ADDR_BYTE, '{x, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        bus_start();
        send_bits(LCD_ADDR_BYTE, 8, 1'b0);
        tb_sda = 1'b1; tick(Q);
        scl = 1'b1; tick(3);
        check("midack sda_driven", 32'(sda), 32'd0);
        check("midack held", 32'({rx_valid, addressed, rx_data}), 32'({2'b11, x}));
        reset_n = 1'b0; #1;
        check("midack sda_released", 32'(sda), 32'd1);
        check("midack outputs_reset",
              32'({rx_data, rx_valid, frame_start, frame_end, addressed, overrun}), 32'd0);
        tick(5); scl = 1'b0; tick(5); scl = 1'b1; tick(5);
        reset_n = 1'b1; tick(10);
        check("postreset idle", 32'({sda, rx_valid, addressed}), 32'({1'b1, 2'b00}));
        got_q.delete(); exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
